// File: rtl/tdm_tx_param.sv
// TDM serial transmitter: one frame word per frame, CHANNELS slots of SLOT_W bits.
// The frame word is staged in a single-entry holding register and shifted out MSB first.
module tdm_tx_param #(
    parameter int CHANNELS   = 4,
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int DIV        = 4,
    parameter int DATA_DELAY = 0
) (
    input  logic                         mclk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
    input  logic [CHANNELS-1:0]          slot_mask,
    output logic                         bclk,
    output logic                         fsync,
    output logic                         tdm_out,
    output logic                         frame_start,
    output logic                         underrun
);

    localparam int FRAME_BITS = CHANNELS * SLOT_W;
    localparam int DIV_W      = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    logic                         run;
    logic [DIV_W-1:0]             div_cnt;
    logic [BIT_W-1:0]             bit_cnt;
    logic [FRAME_BITS-1:0]        shift_reg;
    logic [CHANNELS*SAMPLE_W-1:0] hold_data;
    logic                         hold_full;

    logic                         load;
    logic                         bit_adv;
    logic [DIV_W-1:0]             div_nxt;
    logic [BIT_W-1:0]             bit_nxt;
    logic [FRAME_BITS-1:0]        frame_word;

    assign s_ready = !hold_full;

    // Left-justify each enabled sample in its slot; channel 0 occupies the frame MSBs.
    always_comb begin
        frame_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (hold_full && slot_mask[i])
                frame_word[FRAME_BITS-1-i*SLOT_W -: SAMPLE_W] =
                    hold_data[(CHANNELS-1-i)*SAMPLE_W +: SAMPLE_W];
        end
    end

    // A stopped serializer re-enters as though wrapping into bit 0.
    always_comb begin
        load    = 1'b0;
        bit_adv = 1'b0;
        div_nxt = div_cnt;
        bit_nxt = bit_cnt;
        if (!run) begin
            load    = 1'b1;
            div_nxt = '0;
            bit_nxt = '0;
        end else if (div_cnt == DIV_W'(DIV-1)) begin
            div_nxt = '0;
            bit_adv = 1'b1;
            if (bit_cnt == BIT_W'(FRAME_BITS-1)) begin
                bit_nxt = '0;
                load    = 1'b1;
            end else begin
                bit_nxt = bit_cnt + BIT_W'(1);
            end
        end else begin
            div_nxt = div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            bclk        <= 1'b0;
            fsync       <= 1'b0;
            tdm_out     <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            // A word offered during an underrun load lands in hold for the next frame.
            if (s_valid && !hold_full) begin
                hold_data <= s_data;
                hold_full <= 1'b1;
            end else if (en && load) begin
                hold_full <= 1'b0;
            end

            if (!en) begin
                run         <= 1'b0;
                div_cnt     <= '0;
                bit_cnt     <= '0;
                shift_reg   <= '0;
                bclk        <= 1'b0;
                fsync       <= 1'b0;
                tdm_out     <= 1'b0;
                frame_start <= 1'b0;
                underrun    <= 1'b0;
            end else begin
                run         <= 1'b1;
                div_cnt     <= div_nxt;
                bit_cnt     <= bit_nxt;
                bclk        <= (div_nxt >= DIV_W'(DIV/2));
                fsync       <= (bit_nxt == '0);
                frame_start <= load;
                underrun    <= load && !hold_full;
                // With a one-bit delay the shifter's top bit is the bit just sent.
                if (load) begin
                    shift_reg <= frame_word;
                    if (DATA_DELAY != 0)
                        tdm_out <= shift_reg[FRAME_BITS-1];
                    else
                        tdm_out <= frame_word[FRAME_BITS-1];
                end else if (bit_adv) begin
                    shift_reg <= shift_reg << 1;
                    if (DATA_DELAY != 0)
                        tdm_out <= shift_reg[FRAME_BITS-1];
                    else
                        tdm_out <= shift_reg[FRAME_BITS-2];
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_tx_param.sv
// Directed bench: a 24-bit aligned instance and a 32-bit delayed-data instance share
// one stimulus; each frame is captured bit by bit and compared with hand-built words.
module tb_tdm_tx_param;

    logic         mclk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         s_valid = 1'b0;
    logic [95:0]  s_data0 = '0;
    logic [127:0] s_data1 = '0;
    logic [3:0]   slot_mask = 4'hF;
    logic rdy0, bclk0, fsync0, tdm0, fs0, ur0;
    logic rdy1, bclk1, fsync1, tdm1, fs1, ur1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 mclk = ~mclk;

    tdm_tx_param dut0 (
        .mclk(mclk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(rdy0),
        .s_data(s_data0), .slot_mask(slot_mask), .bclk(bclk0), .fsync(fsync0),
        .tdm_out(tdm0), .frame_start(fs0), .underrun(ur0)
    );

    tdm_tx_param #(.SAMPLE_W(32), .DATA_DELAY(1)) dut1 (
        .mclk(mclk), .rst_n(rst_n), .en(en), .s_valid(s_valid), .s_ready(rdy1),
        .s_data(s_data1), .slot_mask(slot_mask), .bclk(bclk1), .fsync(fsync1),
        .tdm_out(tdm1), .frame_start(fs1), .underrun(ur1)
    );

    typedef struct {
        logic [127:0] data;   // four 32-bit samples, ch0 first
        logic [3:0]   mask;
        logic         push;   // word offered during the previous frame
        logic [127:0] exp0;   // 24-bit instance frame
        logic [127:0] exp1;   // 32-bit instance frame, before the one-bit delay
        logic         ur;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_word(input logic [127:0] d, input logic [3:0] m);
        s_valid   = 1'b1;
        s_data1   = d;
        s_data0   = {d[127:104], d[95:72], d[63:40], d[31:8]};
        slot_mask = m;
    endtask

    task automatic wait_frame_start(input string tag);
        int n = 0;
        while (!fs0 && n < 1200) begin
            @(negedge mclk);
            n++;
        end
        n_vec++;
        if (!fs0) begin
            n_bad++;
            $display("FAIL %s: frame_start not seen within %0d cycles", tag, n);
        end
    endtask

    // Called at the negedge where frame_start is high; ends at the frame's last cycle.
    task automatic capture_frame(input string tag, input logic [127:0] e0, input logic [127:0] e1,
                                 input logic e_ur, input logic do_push,
                                 input logic [127:0] pd, input logic [3:0] pm);
        logic [127:0] g0, g1;
        int bad, fsn, urn;
        g0 = '0; g1 = '0; bad = 0; fsn = 0; urn = 0;
        for (int c = 0; c < 512; c++) begin
            int k;
            if (c > 0) @(negedge mclk);
            k = c / 4;
            if (c % 4 == 0) begin
                g0[127-k] = tdm0;
                g1[127-k] = tdm1;
            end else if (tdm0 !== g0[127-k] || tdm1 !== g1[127-k]) begin
                bad++;
            end
            if (bclk0 !== (c % 4 >= 2) || bclk1 !== (c % 4 >= 2)) bad++;
            if (fsync0 !== (k == 0) || fsync1 !== (k == 0)) bad++;
            fsn += int'(fs0) + int'(fs1);
            urn += int'(ur0) + int'(ur1);
            if (do_push && c == 40) drive_word(pd, pm);
            if (do_push && c == 41) begin
                s_valid = 1'b0;
                chk({tag, " s_ready after push"}, 128'({rdy0, rdy1}), 128'b00);
            end
        end
        chk({tag, " stream aligned"}, g0, e0);
        chk({tag, " stream delayed"}, g1, e1);
        chk({tag, " bclk/fsync/hold errors"}, 128'(bad), 128'd0);
        chk({tag, " frame_start pulses"}, 128'(fsn), 128'd2);
        chk({tag, " underrun pulses"}, 128'(urn), e_ur ? 128'd2 : 128'd0);
    endtask

    function automatic logic [127:0] quiet_outs();
        return 128'({bclk0, fsync0, tdm0, fs0, ur0, bclk1, fsync1, tdm1, fs1, ur1});
    endfunction

    logic [127:0] v_data, v_exp0, w_data, x_data;
    logic         prev;

    initial begin
        tbl[0] = '{128'hA5A5A5C3_12345678_FFFFFFFF_00000101, 4'hF, 1'b1,
                   128'hA5A5A500_12345600_FFFFFF00_00000100,
                   128'hA5A5A5C3_12345678_FFFFFFFF_00000101, 1'b0};
        tbl[1] = '{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 4'b1010, 1'b1,
                   128'h00000000_FFFFFF00_00000000_FFFFFF00,
                   128'h00000000_FFFFFFFF_00000000_FFFFFFFF, 1'b0};
        tbl[2] = '{128'h0, 4'hF, 1'b0, 128'h0, 128'h0, 1'b1};
        tbl[3] = '{128'h80000000_00000000_00000000_00000001, 4'hF, 1'b1,
                   128'h80000000_00000000_00000000_00000000,
                   128'h80000000_00000000_00000000_00000001, 1'b0};
        tbl[4] = '{128'h0F0F0F0F_00000000_00000000_00000000, 4'b0001, 1'b1,
                   128'h0F0F0F00_00000000_00000000_00000000,
                   128'h0F0F0F0F_00000000_00000000_00000000, 1'b0};
        v_data = 128'hC0FFEE11_DEADBEEF_00000000_7654321F;
        v_exp0 = 128'hC0FFEE00_DEADBE00_00000000_76543200;
        w_data = {128{1'b1}};
        x_data = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;

        repeat (3) @(negedge mclk);
        chk("reset outputs", quiet_outs(), 128'h0);
        chk("reset s_ready", 128'({rdy0, rdy1}), 128'b11);
        rst_n = 1'b1;
        @(negedge mclk);
        drive_word(tbl[0].data, tbl[0].mask);
        @(negedge mclk);
        s_valid = 1'b0;
        chk("hold fills while disabled", 128'({rdy0, rdy1}), 128'b00);
        repeat (3) @(negedge mclk);
        chk("outputs idle while disabled", quiet_outs(), 128'h0);
        en = 1'b1;

        prev = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic nxt_push;
            logic [127:0] nd;
            logic [3:0] nm;
            nxt_push = 1'b0; nd = '0; nm = 4'hF;
            if (i < 4) begin
                nxt_push = tbl[i+1].push;
                nd = tbl[i+1].data;
                nm = tbl[i+1].mask;
            end
            wait_frame_start($sformatf("vec%0d", i));
            capture_frame($sformatf("vec%0d", i), tbl[i].exp0, {prev, tbl[i].exp1[127:1]},
                          tbl[i].ur, nxt_push, nd, nm);
            prev = tbl[i].exp1[0];
        end

        // en dropped mid-frame with a word waiting in hold
        wait_frame_start("en_drop");
        chk("en_drop underrun frame", 128'({ur0, ur1}), 128'b11);
        for (int c = 0; c < 164; c++) begin
            if (c > 0) @(negedge mclk);
            if (c == 40) drive_word(v_data, 4'hF);
            if (c == 41) s_valid = 1'b0;
        end
        chk("en_drop bclk before drop", 128'({bclk0, bclk1}), 128'b11);
        en = 1'b0;
        @(negedge mclk);
        chk("en_drop outputs next cycle", quiet_outs(), 128'h0);
        chk("en_drop s_ready held", 128'({rdy0, rdy1}), 128'b00);
        repeat (5) @(negedge mclk);
        chk("en_drop outputs stay low", quiet_outs(), 128'h0);
        en = 1'b1;
        @(negedge mclk);
        chk("en_rise immediate frame_start", 128'({fs0, fs1, fsync0, fsync1}), 128'b1111);
        capture_frame("en_rise frame", v_exp0, {1'b0, v_data[127:1]}, 1'b0, 1'b0, '0, 4'hF);
        prev = v_data[0];

        // reset asserted at bit 57 of a full frame with hold also full
        wait_frame_start("rst_pre");
        capture_frame("rst_pre underrun", 128'h0, {prev, 127'h0}, 1'b1, 1'b1, w_data, 4'hF);
        wait_frame_start("rst_mid");
        for (int c = 0; c < 231; c++) begin
            if (c > 0) @(negedge mclk);
            if (c == 40) drive_word(x_data, 4'hF);
            if (c == 41) s_valid = 1'b0;
        end
        chk("rst_mid data before reset", 128'({tdm0, tdm1, bclk0, rdy0}), 128'b0110);
        rst_n = 1'b0;
        #1;
        chk("rst_mid outputs cleared", quiet_outs(), 128'h0);
        chk("rst_mid s_ready", 128'({rdy0, rdy1}), 128'b11);
        repeat (2) @(negedge mclk);
        rst_n = 1'b1;
        wait_frame_start("rst_post");
        capture_frame("rst_post frame", 128'h0, 128'h0, 1'b1, 1'b0, '0, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_tx_param.md
TDM_TX_PARAM -- requirements
Module: tdm_tx_param

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: TDM slots per frame, range 1..16.
REQ-002 SHALL have parameter SAMPLE_W, default 24: bits per sample, range 8..32, SAMPLE_W <= SLOT_W.
REQ-003 SHALL have parameter SLOT_W, default 32: bits per slot, 16 or 32.
REQ-004 SHALL have parameter DIV, default 4: mclk cycles per serial bit, even, >= 2.
REQ-005 SHALL have parameter DATA_DELAY, default 0: 0 means data aligned to fsync, 1 means data one bit after fsync.
REQ-006 SHALL have port mclk, input, 1: sole clock; all logic rises on posedge mclk.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port en, input, 1: serializer run enable.
REQ-009 SHALL have port s_valid, input, 1: frame word valid.
REQ-010 SHALL have port s_ready, output, 1: holding register empty.
REQ-011 SHALL have port s_data, input, CHANNELS*SAMPLE_W: channel 0 in the MSBs.
REQ-012 SHALL have port slot_mask, input, CHANNELS: bit i=1 enables slot i.
REQ-013 SHALL have port bclk, output, 1: bit clock.
REQ-014 SHALL have port fsync, output, 1: frame sync.
REQ-015 SHALL have port tdm_out, output, 1: serial data, MSB first.
REQ-016 SHALL have port frame_start, output, 1: one-cycle pulse at frame start.
REQ-017 SHALL have port underrun, output, 1: one-cycle pulse when a frame starts with no data.

Function
REQ-018 SHALL define FRAME_BITS = CHANNELS*SLOT_W; default 128 bits = 512 mclk.
REQ-019 SHALL keep div_cnt 0..DIV-1 and bit_cnt 0..FRAME_BITS-1, advancing only while en=1, with bit_cnt wrapping to 0 after FRAME_BITS-1.
REQ-020 SHALL hold each bit for exactly DIV mclk cycles; bclk=0 for div_cnt < DIV/2, else 1; all outputs are registered.
REQ-021 SHALL drive fsync=1 for all DIV cycles of bit_cnt=0, otherwise 0.
REQ-022 SHALL use a single-entry holding register with s_ready = !hold_full; a transfer happens when s_valid&s_ready on a clock edge.
REQ-023 SHALL, at the edge entering bit_cnt=0 and div_cnt=0, load the shift register from hold and empty hold.
REQ-024 SHALL format each slot as the sample left-justified, MSB first, followed by SLOT_W-SAMPLE_W zero LSBs; slots with slot_mask bit=0 output all zeros.
REQ-025 SHALL sample slot_mask at frame load only.
REQ-026 SHALL, if hold is empty at frame load, load all zeros and pulse underrun for 1 cycle, coincident with frame_start.
REQ-027 SHALL, if s_valid arrives in the underrun load cycle itself, accept it into hold for the next frame; there is no bypass into the current frame.
REQ-028 SHALL pulse frame_start for 1 mclk in the first cycle of bit_cnt=0.
REQ-029 SHALL, with DATA_DELAY=1, drive frame bit k during bit period k+1, so the last bit of a frame appears during bit 0 of the next frame; the delayed bit is 0 on the first frame after reset or after en rises.
REQ-030 SHALL, when en=0, hold div_cnt and bit_cnt at 0 and drive bclk, fsync, tdm_out, frame_start and underrun at 0 from the next cycle, while hold content and the s_ready handshake remain active.
REQ-031 SHALL, on en rising, start frame load on the next edge, treating it as the bit_cnt=0 entry.

Reset
REQ-032 SHALL, while rst_n=0, immediately clear all counters, the shift register, the delay bit and hold_full.
REQ-033 SHALL drive outputs bclk=0, fsync=0, tdm_out=0, frame_start=0, underrun=0 and s_ready=1 while in reset.
REQ-034 SHALL, on an assertion of rst_n mid-frame, abort the frame, with the first frame after release treated per REQ-031.

Verification
REQ-035 SHALL cover this scenario: rst_n pulled low at bit 57 -> all outputs 0 and s_ready=1 in the same cycle, and no stale bits after release.
REQ-036 SHALL cover this scenario: defaults, data ch0..ch3=0xA5A5A5, 0x123456, 0xFFFFFF, 0x000001 and mask 4'hF -> 128-bit stream matches each sample plus 8 zero LSBs per slot, fsync high for mclk 0-3 of the frame, and bclk period 4.
REQ-037 SHALL cover this scenario: no s_valid before frame -> frame all zeros, underrun=1 for exactly one cycle, and data given at bit 10 appears in the following frame.
REQ-038 SHALL cover this scenario: slot_mask=4'b1010 with all samples 0xFFFFFF -> slots 0 and 2 zero, slots 1 and 3 as 24 ones plus 8 zeros.
REQ-039 SHALL cover this scenario: DATA_DELAY=1 with ch0=0x800000 -> tdm_out=1 only during bit period 1, and the ch3 LSB slot bit appears in next frame bit 0.
REQ-040 SHALL cover this scenario: en dropped at bit 40 while hold is full -> outputs 0 the next cycle, s_ready stays 0, and on en rising the held word is loaded and the frame restarts at bit 0.
